// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word and RAM handshake types, plus the memory arbiter's
// state and grant-source enums.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } arb_src_t;

endpackage

// File: rtl/memory_arbiter_wdog.sv
// Per-access watchdog for the memory arbiter: a clearable, enabled counter
// that saturates at TIMEOUT_CYCLES-1 and flags expiry there.
module memory_arbiter_wdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic CLK,
  input  logic nRST,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/memory_arbiter.sv
// Serialises instruction-fetch and data requests onto one RAM port with a
// per-access watchdog and sticky error. ARB_RR_EN makes ties round-robin.
//
// state | meaning
// IDLE  | waiting for a request; no RAM strobes
// DACC  | data access in flight, RAM driven from capture registers
// IACC  | instruction fetch in flight, RAM driven from capture registers
// ERR   | RAM error or watchdog expiry; sticky until reset
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      ihit,
  output word_t     iload,
  output logic      dhit,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      arb_err
);

  arb_state_t r_state;
  word_t      r_addr;
  word_t      r_store;
  logic       r_wr;
  logic       r_ren;
  logic       r_wen;
  logic       r_err;

  logic w_dreq;
  logic w_pick_d;
  logic w_pick_i;
  logic w_in_acc;
  logic w_access;
  logic w_rerr;
  logic w_expired;

  assign w_dreq   = dREN | dWEN;
  assign w_in_acc = (r_state == DACC) || (r_state == IACC);
  assign w_access = (ramstate == ACCESS);
  assign w_rerr   = (ramstate == ERROR);

`ifdef ARB_RR_EN
  arb_src_t r_last_grant;
  logic     w_tie;

  assign w_tie    = w_dreq & iREN;
  assign w_pick_d = w_dreq & (~iREN | (r_last_grant == SRC_I));
`else
  assign w_pick_d = w_dreq;
`endif
  assign w_pick_i = iREN & ~w_pick_d;

  // Cleared every IDLE cycle, so each grant starts a fresh count.
  memory_arbiter_wdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_wdog (
    .CLK       (CLK),
    .nRST      (nRST),
    .i_clr     (r_state == IDLE),
    .i_en      (w_in_acc && !w_access && !w_rerr),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_err   <= 1'b0;
`ifdef ARB_RR_EN
      r_last_grant <= SRC_I;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_addr  <= daddr;
            r_store <= dstore;
            r_wr    <= dWEN;
            r_ren   <= ~dWEN;
            r_wen   <= dWEN;
            r_state <= DACC;
`ifdef ARB_RR_EN
            if (w_tie) r_last_grant <= SRC_D;
`endif
          end else if (w_pick_i) begin
            r_addr  <= iaddr;
            r_store <= '0;
            r_wr    <= 1'b0;
            r_ren   <= 1'b1;
            r_wen   <= 1'b0;
            r_state <= IACC;
`ifdef ARB_RR_EN
            if (w_tie) r_last_grant <= SRC_I;
`endif
          end
        end
        DACC, IACC: begin
          if (w_access) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_state <= IDLE;
          end else if (w_rerr || w_expired) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ERR;
          end
        end
        default: begin
          r_ren <= 1'b0;
          r_wen <= 1'b0;
          r_err <= 1'b1;
        end
      endcase
    end
  end

  // Hits are gated by nRST so a reset landing on an ACCESS cycle drops the access.
  assign ihit     = nRST && (r_state == IACC) && w_access;
  assign dhit     = nRST && (r_state == DACC) && w_access;
  assign iload    = ihit ? ramload : '0;
  assign dload    = (dhit && !r_wr) ? ramload : '0;
  assign ramREN   = r_ren;
  assign ramWEN   = r_wen;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign arb_err  = r_err;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter: cycle table plus hand-written
// sequences for watchdog, error stickiness and reset mid-access.
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  logic      CLK;
  logic      nRST;
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  word_t     iload;
  logic      dhit;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      arb_err;

  int n_checks = 0;
  int n_err    = 0;

  memory_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .ihit     (ihit),
    .iload    (iload),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate),
    .arb_err  (arb_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic      ir;
    word_t     ia;
    logic      dr;
    logic      dw;
    word_t     da;
    word_t     ds;
    ramstate_t rs;
    word_t     rl;
    logic      e_ih;
    word_t     e_il;
    logic      e_dh;
    word_t     e_dl;
    logic      e_ren;
    logic      e_wen;
    word_t     e_addr;
    word_t     e_store;
    logic      e_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t v(logic ir, word_t ia, logic dr, logic dw, word_t da, word_t ds,
                             ramstate_t rs, word_t rl, logic eih, word_t eil, logic edh,
                             word_t edl, logic er, logic ew, word_t ea, word_t es, logic ee);
    vec_t t;
    t = '{ir, ia, dr, dw, da, ds, rs, rl, eih, eil, edh, edl, er, ew, ea, es, ee};
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  task automatic reset_pulse(string tag);
    nRST = 1'b0;
    idle_inputs();
    step();
    @(negedge CLK);
    chk({tag, "_err_clr"}, 32'(arb_err), 32'd0);
    chk({tag, "_ren_clr"}, 32'(ramREN), 32'd0);
    step();
    nRST = 1'b1;
  endtask

  initial begin
    int n_busy;
    bit saw_hit;

    vecs[0]  = v(1, 32'h4,   0, 0, 32'h0,   32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[1]  = v(1, 32'h4,   0, 0, 32'h0,   32'h0,        ACCESS, 32'h8C010000, 1, 32'h8C010000, 0, 32'h0,        1, 0, 32'h4,   32'h0,        0);
    vecs[2]  = v(0, 32'h0,   0, 0, 32'h0,   32'h0,        FREE,   32'h8C010000, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[3]  = v(1, 32'h40,  1, 0, 32'h100, 32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[4]  = v(1, 32'h40,  1, 0, 32'h100, 32'h0,        BUSY,   32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0,        0);
    vecs[5]  = v(1, 32'h40,  1, 0, 32'h100, 32'h0,        BUSY,   32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h100, 32'h0,        0);
    vecs[6]  = v(1, 32'h40,  1, 0, 32'h100, 32'h0,        ACCESS, 32'hDEADBEEF, 0, 32'h0,        1, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0,        0);
    vecs[7]  = v(1, 32'h40,  0, 0, 32'h0,   32'h0,        FREE,   32'hDEADBEEF, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[8]  = v(1, 32'h40,  0, 0, 32'h0,   32'h0,        ACCESS, 32'h11112222, 1, 32'h11112222, 0, 32'h0,        1, 0, 32'h40,  32'h0,        0);
    vecs[9]  = v(1, 32'h44,  1, 0, 32'h104, 32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
`ifdef ARB_RR_EN
    vecs[10] = v(1, 32'h44,  1, 0, 32'h104, 32'h0,        ACCESS, 32'h55556666, 1, 32'h55556666, 0, 32'h0,        1, 0, 32'h44,  32'h0,        0);
`else
    vecs[10] = v(1, 32'h44,  1, 0, 32'h104, 32'h0,        ACCESS, 32'h55556666, 0, 32'h0,        1, 32'h55556666, 1, 0, 32'h104, 32'h0,        0);
`endif
    vecs[11] = v(0, 32'h0,   0, 0, 32'h0,   32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[12] = v(0, 32'h0,   1, 1, 32'h200, 32'h12345678, FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[13] = v(0, 32'h0,   0, 0, 32'h999, 32'h0,        ACCESS, 32'hCAFEF00D, 0, 32'h0,        1, 32'h0,        0, 1, 32'h200, 32'h12345678, 0);
    vecs[14] = v(0, 32'h0,   0, 0, 32'h0,   32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[15] = v(1, 32'h80,  0, 0, 32'h0,   32'h0,        FREE,   32'h0,        0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        0);
    vecs[16] = v(1, 32'hFC,  0, 0, 32'h0,   32'h0,        BUSY,   32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h80,  32'h0,        0);
    vecs[17] = v(1, 32'hFC,  0, 0, 32'h0,   32'h0,        ERROR,  32'h0,        0, 32'h0,        0, 32'h0,        1, 0, 32'h80,  32'h0,        0);
    vecs[18] = v(1, 32'hFC,  1, 0, 32'h100, 32'h0,        ACCESS, 32'h77,       0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        1);
    vecs[19] = v(1, 32'hFC,  1, 0, 32'h100, 32'h0,        ACCESS, 32'h77,       0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0,        1);

    // Reset held with a pending fetch: everything quiet.
    nRST = 1'b0;
    idle_inputs();
    iREN = 1'b1; iaddr = 32'h4;
    step();
    step();
    @(negedge CLK);
    chk("rst_ihit",   32'(ihit),   32'd0);
    chk("rst_dhit",   32'(dhit),   32'd0);
    chk("rst_iload",  iload,       32'd0);
    chk("rst_dload",  dload,       32'd0);
    chk("rst_ren",    32'(ramREN), 32'd0);
    chk("rst_wen",    32'(ramWEN), 32'd0);
    chk("rst_addr",   ramaddr,     32'd0);
    chk("rst_store",  ramstore,    32'd0);
    chk("rst_err",    32'(arb_err), 32'd0);
    step();
    nRST = 1'b1;

    for (int k = 0; k < NV; k++) begin
      iREN = vecs[k].ir; iaddr = vecs[k].ia; dREN = vecs[k].dr; dWEN = vecs[k].dw;
      daddr = vecs[k].da; dstore = vecs[k].ds; ramstate = vecs[k].rs; ramload = vecs[k].rl;
      @(negedge CLK);
      chk($sformatf("v%0d_ihit", k),  32'(ihit),    32'(vecs[k].e_ih));
      chk($sformatf("v%0d_iload", k), iload,        vecs[k].e_il);
      chk($sformatf("v%0d_dhit", k),  32'(dhit),    32'(vecs[k].e_dh));
      chk($sformatf("v%0d_dload", k), dload,        vecs[k].e_dl);
      chk($sformatf("v%0d_ren", k),   32'(ramREN),  32'(vecs[k].e_ren));
      chk($sformatf("v%0d_wen", k),   32'(ramWEN),  32'(vecs[k].e_wen));
      chk($sformatf("v%0d_err", k),   32'(arb_err), 32'(vecs[k].e_err));
      if (vecs[k].e_ren || vecs[k].e_wen)
        chk($sformatf("v%0d_addr", k), ramaddr, vecs[k].e_addr);
      if (vecs[k].e_wen)
        chk($sformatf("v%0d_store", k), ramstore, vecs[k].e_store);
      step();
    end

    reset_pulse("rst1");

    // Two long-but-legal accesses back to back: the watchdog must restart per grant.
    for (int a = 0; a < 2; a++) begin
      dREN = 1'b1; daddr = 32'h300 + 32'(a); ramstate = FREE;
      step();
      dREN = 1'b0; ramstate = BUSY;
      repeat (12) step();
      ramstate = ACCESS; ramload = 32'hA0A0_0000 + 32'(a);
      @(negedge CLK);
      chk($sformatf("wdog_clr_dhit%0d", a),  32'(dhit), 32'd1);
      chk($sformatf("wdog_clr_dload%0d", a), dload,     32'hA0A0_0000 + 32'(a));
      step();
      ramstate = FREE;
    end
    @(negedge CLK);
    chk("wdog_clr_err", 32'(arb_err), 32'd0);
    step();

    // Watchdog expiry: count the cycles the read strobe is held before the error.
    dREN = 1'b1; daddr = 32'h310; ramstate = BUSY;
    step();
    dREN = 1'b0;
    n_busy = 0;
    saw_hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (arb_err) break;
      if (ramREN) n_busy++;
      if (dhit) saw_hit = 1'b1;
      step();
    end
    chk("timeout_err",    32'(arb_err), 32'd1);
    chk("timeout_cycles", 32'(n_busy),  32'd16);
    chk("timeout_nohit",  32'(saw_hit), 32'd0);
    chk("timeout_ren0",   32'(ramREN),  32'd0);
    step();

    dREN = 1'b1; iREN = 1'b1; ramstate = ACCESS;
    step();
    step();
    @(negedge CLK);
    chk("err_ignore_ren",  32'(ramREN),    32'd0);
    chk("err_ignore_hit",  32'(dhit|ihit), 32'd0);
    chk("err_sticky",      32'(arb_err),   32'd1);
    step();

    reset_pulse("rst2");

    // Reset lands while a data read is in flight.
    dREN = 1'b1; daddr = 32'h400; ramstate = FREE;
    step();
    @(negedge CLK);
    chk("mid_rst_ren_before", 32'(ramREN), 32'd1);
    chk("mid_rst_addr",       ramaddr,     32'h400);
    step();
    nRST = 1'b0; ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    @(negedge CLK);
    chk("mid_rst_nohit", 32'(dhit), 32'd0);
    step();
    nRST = 1'b1; dREN = 1'b0;
    @(negedge CLK);
    chk("mid_rst_idle_hit", 32'(dhit),   32'd0);
    chk("mid_rst_idle_ren", 32'(ramREN), 32'd0);
    chk("mid_rst_idle_wen", 32'(ramWEN), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Sits directly downstream of the request unit and datapath.
- Takes instruction-fetch and data read/write requests and serialises them onto the single shared RAM port.
- Returns ihit/dhit with load data to the request unit and datapath.
- Fixed data-over-instruction priority, captured request registers, per-access watchdog, sticky error.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles an access may wait for ramstate==ACCESS before error.
- CNT_W, 5: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- nRST  in  1  synchronous active-low reset; sampled on rising CLK
- iREN  in  1  instruction read request
- iaddr  in  32  instruction word address
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- ihit  out  1  instruction access done, one-cycle pulse
- iload  out  32  instruction word, valid when ihit
- dhit  out  1  data access done, one-cycle pulse
- dload  out  32  data read value, valid when dhit on a read
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write value
- ramload  in  32  RAM read value
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- arb_err  out  1  sticky error flag

Behaviour:
- Reset (nRST low at edge):
  - State goes to IDLE.
  - Capture registers, watchdog and arb_err clear to 0.
  - ramREN/ramWEN/ramaddr/ramstore read 0 from the next cycle.
  - ihit/dhit/iload/dload are 0.
  - Reset mid-access abandons it with no hit.
- States: IDLE, DACC, IACC, ERR.
- IDLE:
  - If dREN|dWEN, capture daddr, dstore and the write flag (dWEN has precedence over dREN if both high), then go to DACC.
  - Else if iREN, capture iaddr, then go to IACC.
  - Else stay in IDLE.
  - No RAM strobes are driven in IDLE.
- DACC/IACC:
  - RAM outputs are driven purely from the capture registers; input changes mid-access are ignored.
  - ramWEN = captured write; ramREN = not captured write (IACC: ramREN=1).
  - If ramstate==ACCESS:
    - Same cycle: hit=1; load = ramload (dload only for reads; else 0).
    - Next state: IDLE.
  - If ramstate==ERROR, go to ERR with no hit.
  - Otherwise increment the watchdog; when it reaches TIMEOUT_CYCLES-1 with no ACCESS, go to ERR.
- ERR:
  - arb_err=1, held until reset.
  - All strobes 0, no hits, requests ignored.
- Latency:
  - Request seen in cycle N drives the RAM in cycle N+1.
  - Earliest hit is cycle N+1.
  - The IDLE cycle after every access means back-to-back hits are at least 2 cycles apart.
- Simultaneous requests: data granted; the instruction request waits in IDLE for the next decision.
- Request dropped mid-access: the access completes and the hit still pulses.
- Watchdog clears on every grant.
- hit, iload and dload are 0 whenever not hitting.
- Widths: the watchdog saturates and never wraps.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: a last_grant register (reset = instruction) makes ties round-robin, so the first tie goes to data and the next tie to instruction, alternating.
- Undefined: data always wins ties.
- Single-requester behaviour is identical in both cases.

Decomposition:
- cpu_types_pkg (existing): word_t and ramstate_t are reused.
- cpu_types_pkg additions: arb_state_t {IDLE, DACC, IACC, ERR} and arb_src_t {SRC_I, SRC_D}.
- Sub-module memory_arbiter_wdog: clear/enable/saturating counter with an expired output.

Test Plan:
- Reset: hold nRST=0 with iREN=1 -> all outputs 0. Release -> ramREN=1, ramaddr=iaddr=0x00000004 next cycle; ramstate=ACCESS, ramload=0x8C010000 -> ihit=1, iload=0x8C010000 for exactly one cycle.
- Tie: iREN=dREN=1, daddr=0x100, ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF:
  - dhit, dload=0xDEADBEEF on cycle 3.
  - ihit on the following access.
  - With ARB_RR_EN, the second tie grants instruction first.
- Write: dWEN=dREN=1, daddr=0x200, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dhit on ACCESS with dload=0.
- Timeout: dREN=1, ramstate held BUSY -> arb_err=1 after 16 access cycles, no dhit. Later requests are ignored until nRST pulse.
- ramstate=ERROR during IACC -> ERR next cycle. Changing iaddr mid-access does not alter ramaddr.
- Reset asserted during DACC -> IDLE next cycle, no dhit, strobes 0.
